// File: rtl/ddr4_pkg.sv
// Shared types and constants for the DDR4 command sequencer: FSM states, command codes and
// default timing values.
package ddr4_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StInit  = 3'd1,
    StReady = 3'd2,
    StAct   = 3'd3,
    StRw    = 3'd4,
    StPre   = 3'd5,
    StRef   = 3'd6
  } state_e;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_MRS = 3'd1;
  localparam logic [2:0] CMD_ACT = 3'd2;
  localparam logic [2:0] CMD_RD  = 3'd3;
  localparam logic [2:0] CMD_WR  = 3'd4;
  localparam logic [2:0] CMD_PRE = 3'd5;
  localparam logic [2:0] CMD_REF = 3'd6;

  localparam int unsigned DEF_T_MOD  = 5;
  localparam int unsigned DEF_T_RCD  = 5;
  localparam int unsigned DEF_T_CCD  = 5;
  localparam int unsigned DEF_T_RP   = 5;
  localparam int unsigned DEF_T_RFC  = 8;
  localparam int unsigned DEF_T_REFI = 64;

endpackage

// File: rtl/ddr4_timer.sv
// Loadable down-counter used for every FSM wait; holds at zero until reloaded.
module ddr4_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/ddr4_cmd_sequencer.sv
// DDR4 command sequencer: power-up MRS, then close-page ACT -> RD/WR -> PRE per request with
// periodic auto-refresh slotted between sequences. All command outputs are registered.
module ddr4_cmd_sequencer
  import ddr4_pkg::*;
#(
  parameter int unsigned BG_W   = 2,
  parameter int unsigned BA_W   = 2,
  parameter int unsigned ROW_W  = 16,
  parameter int unsigned COL_W  = 10,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned T_MOD  = DEF_T_MOD,
  parameter int unsigned T_RCD  = DEF_T_RCD,
  parameter int unsigned T_CCD  = DEF_T_CCD,
  parameter int unsigned T_RP   = DEF_T_RP,
  parameter int unsigned T_RFC  = DEF_T_RFC,
  parameter int unsigned T_REFI = DEF_T_REFI
) (
  input  logic             CK_t,
  input  logic             RESET_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [BG_W-1:0]  req_bg,
  input  logic [BA_W-1:0]  req_ba,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  output logic             cmd_valid,
  output logic [2:0]       cmd,
  output logic [BG_W-1:0]  cmd_bg,
  output logic [BA_W-1:0]  cmd_ba,
  output logic [ROW_W-1:0] cmd_addr,
  output logic             init_done,
  output logic             busy,
  output logic             ref_late,
  output logic [2:0]       state_o
);

  localparam logic [CNT_W-1:0] ModLd   = CNT_W'(T_MOD - 1);
  localparam logic [CNT_W-1:0] RcdLd   = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] CcdLd   = CNT_W'(T_CCD - 1);
  localparam logic [CNT_W-1:0] RpLd    = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RfcLd   = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] RefiMax = CNT_W'(T_REFI - 1);

  state_e           state_q, state_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [BG_W-1:0]  cmd_bg_q, cmd_bg_d;
  logic [BA_W-1:0]  cmd_ba_q, cmd_ba_d;
  logic [ROW_W-1:0] cmd_addr_q, cmd_addr_d;
  logic             init_done_q, init_done_d;
  logic             ref_pending_q, ref_pending_d;
  logic             ref_late_q, ref_late_d;
  logic [CNT_W-1:0] refi_cnt_q, refi_cnt_d;
  logic             lat_write_q, lat_write_d;
  logic [BG_W-1:0]  lat_bg_q, lat_bg_d;
  logic [BA_W-1:0]  lat_ba_q, lat_ba_d;
  logic [ROW_W-1:0] lat_row_q, lat_row_d;
  logic [COL_W-1:0] lat_col_q, lat_col_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_zero;
  logic             ref_wrap, ref_clear;

  ddr4_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_i  (CK_t),
    .rst_ni (RESET_n),
    .load_i (tmr_load),
    .value_i(tmr_value),
    .zero_o (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = 1'b0;
    cmd_d       = CMD_NOP;
    cmd_bg_d    = '0;
    cmd_ba_d    = '0;
    cmd_addr_d  = '0;
    init_done_d = init_done_q;
    lat_write_d = lat_write_q;
    lat_bg_d    = lat_bg_q;
    lat_ba_d    = lat_ba_q;
    lat_row_d   = lat_row_q;
    lat_col_d   = lat_col_q;
    tmr_load    = 1'b0;
    tmr_value   = '0;
    ref_clear   = 1'b0;

    // Interval counter runs from the first READY cycle on and never stalls.
    ref_wrap   = init_done_q && (refi_cnt_q == RefiMax);
    refi_cnt_d = !init_done_q ? refi_cnt_q : (ref_wrap ? '0 : refi_cnt_q + CNT_W'(1));

    unique case (state_q)
      StIdle: begin
        state_d     = StInit;
        cmd_valid_d = 1'b1;
        cmd_d       = CMD_MRS;
        tmr_load    = 1'b1;
        tmr_value   = ModLd;
      end
      StInit: begin
        if (tmr_zero) begin
          state_d     = StReady;
          init_done_d = 1'b1;
        end
      end
      StReady: begin
        if (ref_pending_q) begin
          state_d     = StRef;
          cmd_valid_d = 1'b1;
          cmd_d       = CMD_REF;
          tmr_load    = 1'b1;
          tmr_value   = RfcLd;
        end else if (req_valid) begin
          state_d     = StAct;
          lat_write_d = req_write;
          lat_bg_d    = req_bg;
          lat_ba_d    = req_ba;
          lat_row_d   = req_row;
          lat_col_d   = req_col;
          cmd_valid_d = 1'b1;
          cmd_d       = CMD_ACT;
          cmd_bg_d    = req_bg;
          cmd_ba_d    = req_ba;
          cmd_addr_d  = req_row;
          tmr_load    = 1'b1;
          tmr_value   = RcdLd;
        end
      end
      StAct: begin
        if (tmr_zero) begin
          state_d     = StRw;
          cmd_valid_d = 1'b1;
          cmd_d       = lat_write_q ? CMD_WR : CMD_RD;
          cmd_bg_d    = lat_bg_q;
          cmd_ba_d    = lat_ba_q;
          cmd_addr_d  = ROW_W'(lat_col_q);
          tmr_load    = 1'b1;
          tmr_value   = CcdLd;
        end
      end
      StRw: begin
        if (tmr_zero) begin
          state_d     = StPre;
          cmd_valid_d = 1'b1;
          cmd_d       = CMD_PRE;
          cmd_bg_d    = lat_bg_q;
          cmd_ba_d    = lat_ba_q;
          tmr_load    = 1'b1;
          tmr_value   = RpLd;
        end
      end
      StPre: begin
        if (tmr_zero) begin
          state_d = StReady;
        end
      end
      StRef: begin
        if (tmr_zero) begin
          state_d   = StReady;
          ref_clear = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A wrap coinciding with REF completion leaves a fresh refresh owed.
    ref_pending_d = ref_wrap | (ref_pending_q & ~ref_clear);
    ref_late_d    = ref_late_q | (ref_wrap & ref_pending_q);
  end

  always_ff @(posedge CK_t or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q       <= StIdle;
      cmd_valid_q   <= 1'b0;
      cmd_q         <= CMD_NOP;
      cmd_bg_q      <= '0;
      cmd_ba_q      <= '0;
      cmd_addr_q    <= '0;
      init_done_q   <= 1'b0;
      ref_pending_q <= 1'b0;
      ref_late_q    <= 1'b0;
      refi_cnt_q    <= '0;
      lat_write_q   <= 1'b0;
      lat_bg_q      <= '0;
      lat_ba_q      <= '0;
      lat_row_q     <= '0;
      lat_col_q     <= '0;
    end else begin
      state_q       <= state_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_q         <= cmd_d;
      cmd_bg_q      <= cmd_bg_d;
      cmd_ba_q      <= cmd_ba_d;
      cmd_addr_q    <= cmd_addr_d;
      init_done_q   <= init_done_d;
      ref_pending_q <= ref_pending_d;
      ref_late_q    <= ref_late_d;
      refi_cnt_q    <= refi_cnt_d;
      lat_write_q   <= lat_write_d;
      lat_bg_q      <= lat_bg_d;
      lat_ba_q      <= lat_ba_d;
      lat_row_q     <= lat_row_d;
      lat_col_q     <= lat_col_d;
    end
  end

  assign req_ready = (state_q == StReady) && !ref_pending_q;
  assign busy      = (state_q != StReady) && (state_q != StIdle);
  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign cmd_bg    = cmd_bg_q;
  assign cmd_ba    = cmd_ba_q;
  assign cmd_addr  = cmd_addr_q;
  assign init_done = init_done_q;
  assign ref_late  = ref_late_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// Scoreboard bench: expected commands (with issue cycle) are queued at stimulus time and a
// negedge monitor pops and compares every issued command.
`timescale 1ns/1ps
module tb_ddr4_cmd_sequencer;
  import ddr4_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst2_n;
  logic        req_valid, req_ready, req_write;
  logic [1:0]  req_bg, req_ba;
  logic [15:0] req_row;
  logic [9:0]  req_col;
  logic        cmd_valid, init_done, busy, ref_late;
  logic [2:0]  cmd, state_o;
  logic [1:0]  cmd_bg, cmd_ba;
  logic [15:0] cmd_addr;

  logic        req2_ready, cmd2_valid, init2_done, busy2, ref2_late;
  logic [2:0]  cmd2, state2;
  logic [1:0]  cmd2_bg, cmd2_ba;
  logic [15:0] cmd2_addr;

  ddr4_cmd_sequencer dut (
    .CK_t(clk), .RESET_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
    .req_col(req_col), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
    .cmd_addr(cmd_addr), .init_done(init_done), .busy(busy), .ref_late(ref_late),
    .state_o(state_o)
  );

  ddr4_cmd_sequencer #(.T_REFI(8)) dut2 (
    .CK_t(clk), .RESET_n(rst2_n), .req_valid(1'b1), .req_ready(req2_ready),
    .req_write(1'b0), .req_bg(2'd1), .req_ba(2'd1), .req_row(16'h0042),
    .req_col(10'h007), .cmd_valid(cmd2_valid), .cmd(cmd2), .cmd_bg(cmd2_bg), .cmd_ba(cmd2_ba),
    .cmd_addr(cmd2_addr), .init_done(init2_done), .busy(busy2), .ref_late(ref2_late),
    .state_o(state2)
  );

  typedef struct {
    int          cyc;
    logic [2:0]  cmd;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [15:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   r_base = 0;
  bit   chk2_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int c, input logic [2:0] k, input logic [1:0] bg,
                      input logic [1:0] ba, input logic [15:0] a);
    exp_t e;
    e.cyc = c; e.cmd = k; e.bg = bg; e.ba = ba; e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_req(input bit wr, input logic [1:0] bg, input logic [1:0] ba,
                        input logic [15:0] row, input logic [9:0] col, output int n);
    int waited = 0;
    req_valid = 1'b1; req_write = wr; req_bg = bg; req_ba = ba; req_row = row; req_col = col;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL req_accept_timeout: req_ready still 0 after %0d cycles", waited);
      req_valid = 1'b0;
      n = -1;
      return;
    end
    n = cyc;
    push(n + 1, CMD_ACT, bg, ba, row);
    push(n + 6, wr ? CMD_WR : CMD_RD, bg, ba, {6'd0, col});
    push(n + 11, CMD_PRE, bg, ba, 16'h0000);
    @(negedge clk);
  endtask

  // Main DUT monitor.
  always @(negedge clk) begin
    exp_t e;
    if (cmd_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_cmd: got cmd %0d, required none (cycle %0d)", cmd, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("cmd_cycle", cyc, e.cyc);
        chk("cmd_code", cmd, e.cmd);
        chk("cmd_bg", cmd_bg, e.bg);
        chk("cmd_ba", cmd_ba, e.ba);
        chk("cmd_addr", cmd_addr, e.addr);
      end
    end else begin
      chk("nop_when_idle", cmd, CMD_NOP);
    end
  end

  // Short-interval DUT monitor: refresh must sit between PRE and the next ACT.
  logic [2:0] prev2 = CMD_NOP;
  bit         after_ref2 = 1'b0;
  int         refs2 = 0;
  always @(negedge clk) begin
    if (chk2_en) begin
      if (cyc == r_base + 15) chk("ref2_late_early", ref2_late, 1'b0);
      if (cyc == r_base + 16) begin
        chk("ref2_late_set", ref2_late, 1'b1);
        chk("ref2_ready_pending", req2_ready, 1'b0);
      end
      if (cmd2_valid) begin
        if (cmd2 == CMD_REF) begin
          chk("ref2_after_pre", prev2, CMD_PRE);
          chk("ref2_fields", {cmd2_bg, cmd2_ba, cmd2_addr}, 0);
          chk("ref2_state", state2, 3'd6);
          chk("ref2_busy", busy2, 1'b1);
          refs2 <= refs2 + 1;
          after_ref2 <= 1'b1;
        end else if (after_ref2) begin
          chk("ref2_then_act", cmd2, CMD_ACT);
          after_ref2 <= 1'b0;
        end
        prev2 <= cmd2;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0, r, n1, n2, n3, n4, c1;
    rst_n = 1'b0; rst2_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_bg = '0; req_ba = '0; req_row = '0; req_col = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_state", state_o, 3'd0);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_busy", busy, 1'b0);

    c0 = cyc;
    push(c0 + 1, CMD_MRS, 2'd0, 2'd0, 16'h0000);
    rst_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
    chk("init_busy", busy, 1'b1);
    chk("init2_state", state2, 3'd1);
    wait_cyc(c0 + 5);
    chk("ready_before_tmod", req_ready, 1'b0);
    chk("init_done_before_tmod", init_done, 1'b0);
    wait_cyc(c0 + 6);
    chk("init_done_after_tmod", init_done, 1'b1);
    chk("ready_after_tmod", req_ready, 1'b1);
    chk("ready_not_busy", busy, 1'b0);
    chk("init2_done", init2_done, 1'b1);
    r = cyc;
    r_base = r;
    chk2_en = 1'b1;

    // Read, then two writes with req_valid held throughout.
    do_req(1'b0, 2'd1, 2'd2, 16'h1234, 10'h02A, n1);
    chk("read_accept_cycle", n1, r);
    do_req(1'b1, 2'd3, 2'd1, 16'hBEEF, 10'h3FF, n2);
    chk("b2b_accept_1", n2, n1 + 16);
    do_req(1'b1, 2'd0, 2'd3, 16'h0001, 10'h155, n3);
    chk("b2b_accept_2", n3, n2 + 16);
    req_valid = 1'b0;
    chk("seq_busy", busy, 1'b1);
    chk("seq_not_ready", req_ready, 1'b0);

    // Idle refresh at T_REFI=64 with T_RFC=8.
    push(r + 65, CMD_REF, 2'd0, 2'd0, 16'h0000);
    push(r + 129, CMD_REF, 2'd0, 2'd0, 16'h0000);
    wait_cyc(r + 63);
    chk("ready_before_wrap", req_ready, 1'b1);
    wait_cyc(r + 64);
    chk("ready_low_pending", req_ready, 1'b0);
    wait_cyc(r + 72);
    chk("ready_low_trfc_end", req_ready, 1'b0);
    wait_cyc(r + 73);
    chk("ready_after_ref", req_ready, 1'b1);
    wait_cyc(r + 136);
    chk("ready_low_ref2", req_ready, 1'b0);
    wait_cyc(r + 137);
    chk("ready_after_ref2", req_ready, 1'b1);
    chk("ref_late_idle", ref_late, 1'b0);

    chk2_en = 1'b0;
    chk("ref2_late_final", ref2_late, 1'b1);
    chk("ref2_count", refs2 >= 3, 1'b1);

    // Reset asserted in the RW wait: no stale PRE, fresh MRS on restart.
    wait_cyc(r + 140);
    do_req(1'b0, 2'd2, 2'd1, 16'hABCD, 10'h001, n4);
    req_valid = 1'b0;
    wait_cyc(n4 + 8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cmd_valid", cmd_valid, 1'b0);
    chk("arst_cmd", cmd, CMD_NOP);
    chk("arst_state", state_o, 3'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_init_done", init_done, 1'b0);
    chk("arst_cmd_addr", cmd_addr, 16'h0000);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge clk);
    @(negedge clk);
    c1 = cyc;
    push(c1 + 1, CMD_MRS, 2'd0, 2'd0, 16'h0000);
    rst_n = 1'b1;
    wait_cyc(c1 + 6);
    chk("reinit_done", init_done, 1'b1);
    chk("reinit_ready", req_ready, 1'b1);
    wait_cyc(c1 + 30);
    chk("exp_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
